// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and bench defaults.
package sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout set when the difference goes negative.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock LSB first,
// sequenced by a start/busy/done handshake around a single full_sub_cell.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_sub_cell u_cell (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // New operands are only accepted when no operation is in flight (IDLE or the DONE cycle).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      sh_a <= a;
      sh_b <= b;
      br   <= borrow_in;
      res  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      br   <= cell_bout;
      res  <= {cell_d, res[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      // Outputs change only here, with the final bit folded in, so they never show partial results.
      if (last_bit) begin
        diff       <= {cell_d, res[WIDTH-1:1]};
        borrow_out <= cell_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: expected results queued at start, checked on every done pulse.
module tb_serial_sub;
  import sub_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  logic cx = 1'b0, cy = 1'b0, cbin = 1'b0;
  logic cd, cbout;

  int n_cmp = 0;
  int n_err = 0;

  logic [W:0]   sb[$];
  logic [W-1:0] exp_diff = '0;
  logic         exp_bo = 1'b0;
  logic         prev_done = 1'b0;

  serial_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  full_sub_cell u_cell_chk (
    .x    (cx),
    .y    (cy),
    .bin  (cbin),
    .d    (cd),
    .bout (cbout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    return r;
  endfunction

  // Monitor: outputs must always equal the last expected completion (or zero after reset).
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_diff  = '0;
      exp_bo    = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = sb.pop_front();
          exp_diff = e[W-1:0];
          exp_bo   = e[W];
        end
      end
      check("diff", {{(32-W){1'b0}}, diff}, {{(32-W){1'b0}}, exp_diff});
      check("borrow_out", {31'd0, borrow_out}, {31'd0, exp_bo});
      prev_done = done;
    end
  end

  // Drive one start cycle; inputs change #1 after the edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi, input bit push);
    start     = 1'b1;
    a         = xa;
    b         = xb;
    borrow_in = xbi;
    if (push) sb.push_back(model(xa, xb, xbi));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 3 * W + 6) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;

    for (int v = 0; v < 8; v++) begin
      int r;
      logic [2:0] vv;
      vv = v[2:0];
      {cx, cy, cbin} = vv;
      #1;
      r = int'(cx) - int'(cy) - int'(cbin);
      check("cell_d", {31'd0, cd}, {31'd0, r[0]});
      check("cell_bout", {31'd0, cbout}, {31'd0, (r < 0)});
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {{(32-W){1'b0}}, diff}, 32'd0);
    check("rst_bo", {31'd0, borrow_out}, 32'd0);

    // 9 - 3: busy for W cycles, done right after
    issue(4'd9, 4'd3, 1'b0, 1'b1);
    check("lat_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      check("lat_busy", {31'd0, busy}, 32'd1);
      check("lat_nodone", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("lat_done", {31'd0, done}, 32'd1);
    check("lat_busy_off", {31'd0, busy}, 32'd0);
    check("lat_diff", {{(32-W){1'b0}}, diff}, 32'h6);
    @(posedge clk);
    #1;
    check("lat_done_off", {31'd0, done}, 32'd0);

    issue(4'd3, 4'd9, 1'b0, 1'b1);
    wait_done(n);
    @(posedge clk); #1;
    issue(4'd0, 4'd0, 1'b1, 1'b1);
    wait_done(n);
    @(posedge clk); #1;
    issue(4'hF, 4'hF, 1'b1, 1'b1);
    wait_done(n);
    @(posedge clk); #1;

    // start while busy must be ignored
    issue(4'd5, 4'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    issue(4'd1, 4'd1, 1'b0, 1'b0);
    wait_done(n);
    check("ign_diff", {{(32-W){1'b0}}, diff}, 32'h3);
    @(posedge clk); #1;

    // start held through DONE: accepted there, next done W+1 cycles later
    issue(4'd6, 4'd1, 1'b0, 1'b1);
    start = 1'b1;
    a     = 4'd8;
    b     = 4'd1;
    sb.push_back(model(4'd8, 4'd1, 1'b0));
    wait_done(n);
    @(posedge clk); #1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    n     = 1;
    while (!done && n < 3 * W + 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_gap", n, W + 1);
    check("b2b_diff", {{(32-W){1'b0}}, diff}, 32'h7);
    @(posedge clk); #1;

    // reset mid-operation aborts
    issue(4'd9, 4'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_diff", {{(32-W){1'b0}}, diff}, 32'd0);
    check("abort_bo", {31'd0, borrow_out}, 32'd0);
    repeat (2 * W + 2) @(posedge clk);
    #1;
    check("abort_nodone", {31'd0, done}, 32'd0);
    issue(4'd7, 4'd7, 1'b0, 1'b1);
    wait_done(n);
    check("after_abort_diff", {{(32-W){1'b0}}, diff}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 50; k++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom_range(0, 1));
      issue(ra, rb, rbi, 1'b1);
      // scramble inputs while busy; they must not matter
      a = W'($urandom);
      b = W'($urandom);
      borrow_in = 1'($urandom_range(0, 1));
      wait_done(n);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
